// File: rtl/wide_add_sequencer_if.sv
`timescale 1ns/1ps
// Operand request / result response bus of the multi-precision add/sub engine.
interface wide_add_sequencer_if #(
    parameter int unsigned N = 96
);
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/wide_add_sequencer.sv
`timescale 1ns/1ps
// Multi-precision add/subtract: one WIDTH-bit ripple-carry adder reused across
// CHUNKS cycles, LS chunk first, carry registered between chunks.

module ripple_carry_adder #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[WIDTH];
    end
endmodule

module wide_add_sequencer #(
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned CHUNKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    wide_add_sequencer_if.slave bus
);
    localparam int unsigned N     = WIDTH * CHUNKS;
    localparam int unsigned IDX_W = $clog2(CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   add_a, add_b, add_s;
    logic               add_co;

    // Chunk selected by idx feeds the shared adder.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                add_a = a_q[i*WIDTH +: WIDTH];
                add_b = b_q[i*WIDTH +: WIDTH];
            end
        end
    end

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < CHUNKS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*WIDTH +: WIDTH] = add_s;
                    end
                end
                carry_d = add_co;
                if (idx_q == IDX_W'(CHUNKS - 1)) begin
                    // b_q already holds ~b for subtraction, so one rule covers both ops.
                    cout_d  = add_co;
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (add_s[WIDTH-1] != a_q[N-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
`timescale 1ns/1ps
// Directed + random bench for wide_add_sequencer against an arithmetic reference.
module tb_wide_add_sequencer;
    localparam int unsigned WIDTH  = 24;
    localparam int unsigned CHUNKS = 4;
    localparam int unsigned N      = WIDTH * CHUNKS;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    wide_add_sequencer_if #(.N(N)) bus ();

    wide_add_sequencer #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference: plain N+1-bit arithmetic and signed-overflow rules.
    function automatic void ref_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                                   output logic [N-1:0] s, output logic co, output logic ov);
        logic [N:0] wide;
        if (!sub) begin
            wide = {1'b0, a} + {1'b0, b};
            s    = wide[N-1:0];
            co   = wide[N];
            ov   = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
        end else begin
            s  = a - b;
            co = (a >= b);
            ov = (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
        end
    endfunction

    function automatic logic [N-1:0] rand_wide();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Accept one op and wait for out_valid; all tasks start/end 1 time unit after a rising edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                         input string tag, output logic [N-1:0] es);
        logic ec, eo;
        int   cnt;
        ref_op(a, b, sub, es, ec, eo);
        chk1({tag, ".in_ready_idle"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op_sub   = sub;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = rand_wide();
        bus.b        = rand_wide();
        bus.op_sub   = ~sub;
        chk1({tag, ".in_ready_run"}, bus.in_ready, 1'b0);
        chk1({tag, ".busy_run"}, bus.busy, 1'b1);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, ".latency"}, N'(cnt), N'(CHUNKS));
        chk({tag, ".sum"}, bus.sum, es);
        chk1({tag, ".cout"}, bus.cout, ec);
        chk1({tag, ".ovf"}, bus.ovf, eo);
        chk1({tag, ".in_ready_done"}, bus.in_ready, 1'b0);
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk1({tag, ".out_valid_drop"}, bus.out_valid, 1'b0);
        chk1({tag, ".in_ready_back"}, bus.in_ready, 1'b1);
        chk1({tag, ".busy_idle"}, bus.busy, 1'b0);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          input int stall, input string tag, output logic [N-1:0] es);
        issue(a, b, sub, tag, es);
        repeat (stall) begin
            @(posedge clk); #1;
            chk1({tag, ".hold_valid"}, bus.out_valid, 1'b1);
            chk({tag, ".hold_sum"}, bus.sum, es);
        end
        release_out(tag);
    endtask

    initial begin
        logic [N-1:0] ones, msb, maxpos, es, ra, rb;
        logic         rs;
        int           mode;
        ones   = '1;
        msb    = {1'b1, {(N-1){1'b0}}};
        maxpos = {1'b0, {(N-1){1'b1}}};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        chk1("reset.in_ready", bus.in_ready, 1'b1);
        chk1("reset.out_valid", bus.out_valid, 1'b0);
        chk1("reset.busy", bus.busy, 1'b0);
        chk("reset.sum", bus.sum, '0);
        chk1("reset.cout", bus.cout, 1'b0);
        chk1("reset.ovf", bus.ovf, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Carry and borrow chains, signed overflow.
        run_op(ones, N'(1), 1'b0, 0, "carry_chain", es);
        chk("carry_chain.const", es, '0);
        run_op('0, N'(1), 1'b1, 0, "borrow_chain", es);
        chk("borrow_chain.const", es, ones);
        run_op(N'(5), N'(5), 1'b1, 1, "sub_equal", es);
        run_op(maxpos, N'(1), 1'b0, 0, "ovf_add", es);
        chk("ovf_add.const", es, msb);
        run_op(msb, N'(1), 1'b1, 0, "ovf_sub", es);
        chk("ovf_sub.const", es, maxpos);
        run_op(rand_wide(), '0, 1'b1, 0, "sub_zero", es);

        // Backpressure with an ignored in_valid pulse during DONE.
        issue(N'(100), N'(23), 1'b0, "bp", es);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 4);
            bus.a        = N'(7);
            bus.b        = N'(9);
            @(posedge clk); #1;
            chk1("bp.hold_valid", bus.out_valid, 1'b1);
            chk1("bp.hold_in_ready", bus.in_ready, 1'b0);
            chk("bp.hold_sum", bus.sum, N'(123));
        end
        bus.in_valid = 1'b0;
        release_out("bp");
        run_op(N'(7), N'(9), 1'b0, 0, "bp_next", es);

        // Reset in the middle of RUN, at idx=2.
        bus.in_valid = 1'b1;
        bus.a        = ones;
        bus.b        = ones;
        bus.op_sub   = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk1("rst_run.out_valid", bus.out_valid, 1'b0);
        chk("rst_run.sum", bus.sum, '0);
        chk1("rst_run.in_ready", bus.in_ready, 1'b1);
        chk1("rst_run.busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(N'(24'h123456), N'(24'hABCDEF), 1'b0, 0, "post_rst", es);
        chk("post_rst.const", es, N'(24'hBE0245));

        // Reset while a result is waiting in DONE.
        issue(N'(1), N'(2), 1'b0, "rst_done", es);
        rst = 1'b1;
        #1;
        chk1("rst_done.out_valid", bus.out_valid, 1'b0);
        chk("rst_done.sum", bus.sum, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random operations with random result stalls.
        for (int k = 0; k < 1000; k++) begin
            mode = int'($urandom_range(0, 7));
            ra   = (mode == 0) ? ones : ((mode == 1) ? msb : rand_wide());
            rb   = (mode == 2) ? '0 : ((mode == 3) ? N'(1) : rand_wide());
            rs   = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), "random", es);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
